// File: rtl/hnf_sf_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hnf_sf_ctrl : HN-F snoop-filter SRAM controller (clear, arbitrate, compare, victim)
// Rev 1.0
// ----------------------------------------------------------------------------
module hnf_sf_ctrl #(
  parameter int SF_INDEX_WIDTH = 10,
  parameter int SF_WAY_NUM     = 8,
  parameter int SF_TAG_WIDTH   = 20,
  parameter int SF_PRES_WIDTH  = 4,
  parameter int SF_RD_LAT      = 2,
  localparam int CLW           = 1 + SF_PRES_WIDTH + SF_TAG_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_done,
  input  logic                           lkp_valid,
  output logic                           lkp_ready,
  input  logic [SF_INDEX_WIDTH-1:0]      lkp_index,
  input  logic [SF_TAG_WIDTH-1:0]        lkp_tag,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [SF_INDEX_WIDTH-1:0]      upd_index,
  input  logic [SF_WAY_NUM-1:0]          upd_ways,
  input  logic [CLW-1:0]                 upd_cline,
  output logic                           rsp_valid,
  output logic                           rsp_hit,
  output logic [SF_WAY_NUM-1:0]          rsp_hit_way,
  output logic [SF_PRES_WIDTH-1:0]       rsp_pres,
  output logic [SF_WAY_NUM-1:0]          rsp_vic_way,
  output logic [CLW-1:0]                 rsp_vic_cline,
  output logic                           rsp_multi_hit,
  output logic [SF_INDEX_WIDTH-1:0]      sf_index_q,
  output logic                           sf_rd_en_q,
  output logic [SF_WAY_NUM-1:0]          sf_wr_ways_q,
  output logic [CLW-1:0]                 sf_wr_cline_q,
  input  logic [CLW*SF_WAY_NUM-1:0]      sf_rd_clines_q
);

  localparam int RRW = (SF_WAY_NUM > 1) ? $clog2(SF_WAY_NUM) : 1;
  localparam logic [SF_WAY_NUM-1:0] WAY_ONE = SF_WAY_NUM'(1);
  localparam logic [RRW-1:0] RR_LAST = RRW'(SF_WAY_NUM - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [SF_INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                      init_done_q, init_done_d;
  logic [SF_INDEX_WIDTH-1:0] sf_index_d;
  logic                      sf_rd_en_d;
  logic [SF_WAY_NUM-1:0]     sf_wr_ways_d;
  logic [CLW-1:0]            sf_wr_cline_d;
  logic [RRW-1:0]            rr_q, rr_d;

  logic                      rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_multi_q, rsp_multi_d;
  logic [SF_WAY_NUM-1:0]     rsp_hit_way_q, rsp_hit_way_d, rsp_vic_way_q, rsp_vic_way_d;
  logic [SF_PRES_WIDTH-1:0]  rsp_pres_q, rsp_pres_d;
  logic [CLW-1:0]            rsp_vic_cline_q, rsp_vic_cline_d;

  // Tracking pipe: stage s holds the lookup whose SRAM read was issued s cycles ago.
  logic                                pv_q    [0:SF_RD_LAT];
  logic                                pv_d    [0:SF_RD_LAT];
  logic [SF_INDEX_WIDTH-1:0]           pidx_q  [0:SF_RD_LAT];
  logic [SF_INDEX_WIDTH-1:0]           pidx_d  [0:SF_RD_LAT];
  logic [SF_TAG_WIDTH-1:0]             ptag_q  [0:SF_RD_LAT];
  logic [SF_TAG_WIDTH-1:0]             ptag_d  [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0]               pmask_q [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0]               pmask_d [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0]               pmask_c [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0][CLW-1:0]      pdat_q  [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0][CLW-1:0]      pdat_d  [0:SF_RD_LAT];
  logic [SF_WAY_NUM-1:0][CLW-1:0]      pdat_c  [0:SF_RD_LAT];

  logic [SF_WAY_NUM-1:0][CLW-1:0] merged;
  logic [SF_WAY_NUM-1:0] hits, valids, hit_oh, inv_oh, vic_oh;
  logic [SF_PRES_WIDTH-1:0] hit_pres;
  logic [CLW-1:0] vic_cline;
  logic lkp_acc, upd_acc;

  assign upd_ready = init_done_q;
  assign lkp_ready = init_done_q & ~upd_valid;
  assign upd_acc   = upd_valid & init_done_q;
  assign lkp_acc   = lkp_valid & lkp_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
    sf_index_d    = sf_index_q;
    sf_rd_en_d    = 1'b0;
    sf_wr_ways_d  = '0;
    sf_wr_cline_d = sf_wr_cline_q;
    case (state_q)
      ST_INIT: begin
        sf_index_d    = cnt_q;
        sf_wr_ways_d  = '1;
        sf_wr_cline_d = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: begin
        init_done_d = 1'b1;
        if (upd_acc) begin
          sf_index_d    = upd_index;
          sf_wr_ways_d  = upd_ways;
          sf_wr_cline_d = upd_cline;
        end else if (lkp_acc) begin
          sf_index_d = lkp_index;
          sf_rd_en_d = 1'b1;
        end
      end
    endcase
  end

  // Fold the write currently presented to the SRAM into every matching in-flight lookup.
  always_comb begin
    for (int s = 0; s <= SF_RD_LAT; s++) begin
      for (int w = 0; w < SF_WAY_NUM; w++) begin
        pmask_c[s][w] = pmask_q[s][w] | (pv_q[s] & sf_wr_ways_q[w] & (pidx_q[s] == sf_index_q));
        pdat_c[s][w]  = (pv_q[s] & sf_wr_ways_q[w] & (pidx_q[s] == sf_index_q)) ?
                        sf_wr_cline_q : pdat_q[s][w];
      end
    end
  end

  always_comb begin
    pv_d[0]    = lkp_acc;
    pidx_d[0]  = lkp_index;
    ptag_d[0]  = lkp_tag;
    pmask_d[0] = '0;
    pdat_d[0]  = '0;
    for (int s = 1; s <= SF_RD_LAT; s++) begin
      pv_d[s]    = pv_q[s-1];
      pidx_d[s]  = pidx_q[s-1];
      ptag_d[s]  = ptag_q[s-1];
      pmask_d[s] = pmask_c[s-1];
      pdat_d[s]  = pdat_c[s-1];
    end
  end

  always_comb begin
    hit_pres  = '0;
    vic_cline = '0;
    for (int w = 0; w < SF_WAY_NUM; w++) begin
      merged[w] = pmask_c[SF_RD_LAT][w] ? pdat_c[SF_RD_LAT][w] : sf_rd_clines_q[w*CLW +: CLW];
      valids[w] = merged[w][CLW-1];
      hits[w]   = merged[w][CLW-1] & (merged[w][SF_TAG_WIDTH-1:0] == ptag_q[SF_RD_LAT]);
    end
    hit_oh = hits & (~hits + WAY_ONE);
    inv_oh = ~valids & (valids + WAY_ONE);
    vic_oh = (&valids) ? (WAY_ONE << rr_q) : inv_oh;
    for (int w = 0; w < SF_WAY_NUM; w++) begin
      if (hit_oh[w]) hit_pres  = merged[w][CLW-2 -: SF_PRES_WIDTH];
      if (vic_oh[w]) vic_cline = merged[w];
    end
  end

  always_comb begin
    rsp_valid_d     = pv_q[SF_RD_LAT];
    rsp_hit_d       = rsp_hit_q;
    rsp_hit_way_d   = rsp_hit_way_q;
    rsp_pres_d      = rsp_pres_q;
    rsp_vic_way_d   = rsp_vic_way_q;
    rsp_vic_cline_d = rsp_vic_cline_q;
    rsp_multi_d     = rsp_multi_q;
    rr_d            = rr_q;
    if (pv_q[SF_RD_LAT]) begin
      rsp_hit_d       = |hits;
      rsp_hit_way_d   = hit_oh;
      rsp_pres_d      = hit_pres;
      rsp_vic_way_d   = vic_oh;
      rsp_vic_cline_d = vic_cline;
      rsp_multi_d     = |(hits & (hits - WAY_ONE));
      if (~|hits & (&valids)) rr_d = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      init_done_q     <= 1'b0;
      sf_index_q      <= '0;
      sf_rd_en_q      <= 1'b0;
      sf_wr_ways_q    <= '0;
      sf_wr_cline_q   <= '0;
      rr_q            <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_hit_way_q   <= '0;
      rsp_pres_q      <= '0;
      rsp_vic_way_q   <= '0;
      rsp_vic_cline_q <= '0;
      rsp_multi_q     <= 1'b0;
      for (int s = 0; s <= SF_RD_LAT; s++) begin
        pv_q[s]    <= 1'b0;
        pidx_q[s]  <= '0;
        ptag_q[s]  <= '0;
        pmask_q[s] <= '0;
        pdat_q[s]  <= '0;
      end
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      init_done_q     <= init_done_d;
      sf_index_q      <= sf_index_d;
      sf_rd_en_q      <= sf_rd_en_d;
      sf_wr_ways_q    <= sf_wr_ways_d;
      sf_wr_cline_q   <= sf_wr_cline_d;
      rr_q            <= rr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_hit_way_q   <= rsp_hit_way_d;
      rsp_pres_q      <= rsp_pres_d;
      rsp_vic_way_q   <= rsp_vic_way_d;
      rsp_vic_cline_q <= rsp_vic_cline_d;
      rsp_multi_q     <= rsp_multi_d;
      pv_q            <= pv_d;
      pidx_q          <= pidx_d;
      ptag_q          <= ptag_d;
      pmask_q         <= pmask_d;
      pdat_q          <= pdat_d;
    end
  end

  assign init_done     = init_done_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_hit_way   = rsp_hit_way_q;
  assign rsp_pres      = rsp_pres_q;
  assign rsp_vic_way   = rsp_vic_way_q;
  assign rsp_vic_cline = rsp_vic_cline_q;
  assign rsp_multi_hit = rsp_multi_q;

endmodule
`default_nettype wire

// File: tb/tb_hnf_sf_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_hnf_sf_ctrl : directed self-checking bench for hnf_sf_ctrl with an SRAM model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hnf_sf_ctrl;
  localparam int IW = 10, WN = 8, TW = 20, PW = 4, LAT = 2;
  localparam int CLW = 1 + PW + TW;

  logic clk = 1'b0;
  logic rst;
  logic init_done, lkp_valid, lkp_ready, upd_valid, upd_ready;
  logic [IW-1:0] lkp_index, upd_index, sf_index_q;
  logic [TW-1:0] lkp_tag;
  logic [WN-1:0] upd_ways, rsp_hit_way, rsp_vic_way, sf_wr_ways_q;
  logic [CLW-1:0] upd_cline, rsp_vic_cline, sf_wr_cline_q;
  logic rsp_valid, rsp_hit, rsp_multi_hit, sf_rd_en_q;
  logic [PW-1:0] rsp_pres;
  logic [CLW*WN-1:0] sf_rd_clines_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hnf_sf_ctrl #(.SF_INDEX_WIDTH(IW), .SF_WAY_NUM(WN), .SF_TAG_WIDTH(TW),
                .SF_PRES_WIDTH(PW), .SF_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_ways(upd_ways), .upd_cline(upd_cline),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way), .rsp_pres(rsp_pres),
    .rsp_vic_way(rsp_vic_way), .rsp_vic_cline(rsp_vic_cline), .rsp_multi_hit(rsp_multi_hit),
    .sf_index_q(sf_index_q), .sf_rd_en_q(sf_rd_en_q), .sf_wr_ways_q(sf_wr_ways_q),
    .sf_wr_cline_q(sf_wr_cline_q), .sf_rd_clines_q(sf_rd_clines_q)
  );

  // Single-port SRAM model, read data valid LAT cycles after the read cycle.
  logic [CLW-1:0] mem [0:(1<<IW)-1][0:WN-1];
  logic [CLW*WN-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    for (int w = 0; w < WN; w++) begin
      if (sf_wr_ways_q[w]) mem[sf_index_q][w] <= sf_wr_cline_q;
      if (sf_rd_en_q) rd_p1[w*CLW +: CLW] <= mem[sf_index_q][w];
    end
    rd_p2 <= rd_p1;
  end
  assign sf_rd_clines_q = rd_p2;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [CLW-1:0] mk_cl(input logic v, input logic [PW-1:0] p, input logic [TW-1:0] t);
    return {v, p, t};
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic upd_one(input logic [IW-1:0] idx, input logic [WN-1:0] ways, input logic [CLW-1:0] cl);
    upd_valid = 1'b1; upd_index = idx; upd_ways = ways; upd_cline = cl;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // lat counts cycles after the acceptance edge; already at cycle 'start'.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic lkp_rsp(input logic [IW-1:0] idx, input logic [TW-1:0] tag, output int lat);
    lkp_valid = 1'b1; lkp_index = idx; lkp_tag = tag;
    @(negedge clk);
    lkp_valid = 1'b0;
    wait_rsp(1, lat);
  endtask

  task automatic check_rsp(input string tag, input logic hit, input logic [WN-1:0] hway,
                           input logic [PW-1:0] pres, input logic multi, input logic [WN-1:0] vway);
    check_val({tag, "_valid"}, rsp_valid, 1'b1);
    check_val({tag, "_hit"}, rsp_hit, hit);
    check_val({tag, "_hit_way"}, rsp_hit_way, hway);
    check_val({tag, "_pres"}, rsp_pres, pres);
    check_val({tag, "_multi"}, rsp_multi_hit, multi);
    check_val({tag, "_vic_way"}, rsp_vic_way, vway);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, errs, seen;
    logic [WN-1:0] m;
    rst = 1'b1; lkp_valid = 1'b0; upd_valid = 1'b0;
    lkp_index = '0; lkp_tag = '0; upd_index = '0; upd_ways = '0; upd_cline = '0;
    repeat (3) @(negedge clk);
    check_val("rst_init_done", init_done, 1'b0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_wr_ways", sf_wr_ways_q, 8'h00);
    check_val("rst_upd_ready", upd_ready, 1'b0);

    // Init sweep: lookups requested throughout must not be taken.
    rst = 1'b0; lkp_valid = 1'b1; lkp_index = 10'd3; lkp_tag = 20'h1;
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (sf_index_q !== 10'(k) || sf_wr_ways_q !== 8'hFF || sf_wr_cline_q !== '0 ||
          sf_rd_en_q !== 1'b0 || init_done !== 1'b0 || lkp_ready !== 1'b0) errs++;
    end
    check_val("init_sweep_errs", errs, 0);
    @(negedge clk);
    check_val("init_done_rise", init_done, 1'b1);
    check_val("init_wr_stop", sf_wr_ways_q, 8'h00);
    check_val("init_lkp_ready", lkp_ready, 1'b1);
    check_val("init_upd_ready", upd_ready, 1'b1);
    lkp_valid = 1'b0;
    @(negedge clk);
    check_val("idle_rd_en", sf_rd_en_q, 1'b0);

    // Basic hit with latency check.
    upd_one(10'd5, 8'h08, mk_cl(1'b1, 4'b0010, 20'h12345));
    check_val("upd_index", sf_index_q, 10'd5);
    check_val("upd_ways", sf_wr_ways_q, 8'h08);
    check_val("upd_cline", sf_wr_cline_q, mk_cl(1'b1, 4'b0010, 20'h12345));
    lkp_valid = 1'b1; lkp_index = 10'd5; lkp_tag = 20'h12345;
    @(negedge clk);
    lkp_valid = 1'b0;
    check_val("lkp_rd_en", sf_rd_en_q, 1'b1);
    check_val("lkp_index", sf_index_q, 10'd5);
    check_val("lkp_wr_ways", sf_wr_ways_q, 8'h00);
    wait_rsp(1, lat);
    check_val("hit_latency", lat, 4);
    check_rsp("hit5", 1'b1, 8'h08, 4'b0010, 1'b0, 8'h01);
    check_val("hit5_vic_cline", rsp_vic_cline, '0);
    @(negedge clk);
    check_val("rsp_pulse", rsp_valid, 1'b0);
    check_val("rsp_hold_way", rsp_hit_way, 8'h08);

    // Full set: round-robin victims on misses.
    for (int w = 0; w < WN; w++) begin
      m = 8'h01 << w;
      upd_one(10'd7, m, mk_cl(1'b1, 4'b0000, 20'h700 + 20'(w)));
    end
    for (int i = 0; i < 9; i++) begin
      lkp_rsp(10'd7, 20'hFFFFF, lat);
      m = 8'h01 << (i % 8);
      check_val($sformatf("rr_miss%0d_hit", i), rsp_hit, 1'b0);
      check_val($sformatf("rr_miss%0d_vic", i), rsp_vic_way, m);
      if (i == 2) check_val("rr_miss2_vic_cline", rsp_vic_cline, mk_cl(1'b1, 4'b0000, 20'h702));
    end
    lkp_rsp(10'd7, 20'h703, lat);
    check_rsp("full_hit", 1'b1, 8'h08, 4'b0000, 1'b0, 8'h02);
    lkp_rsp(10'd7, 20'h12345, lat);
    check_rsp("rr_after_hit", 1'b0, 8'h00, 4'b0000, 1'b0, 8'h02);

    // Bypass: update to the same set one cycle after the lookup.
    lkp_valid = 1'b1; lkp_index = 10'd9; lkp_tag = 20'hABCDE;
    @(negedge clk);
    lkp_valid = 1'b0;
    upd_one(10'd9, 8'h03, mk_cl(1'b1, 4'b0101, 20'hABCDE));
    wait_rsp(2, lat);
    check_val("byp_latency", lat, 4);
    check_rsp("byp9", 1'b1, 8'h01, 4'b0101, 1'b1, 8'h04);
    lkp_rsp(10'd9, 20'hABCDE, lat);
    check_rsp("mem9", 1'b1, 8'h01, 4'b0101, 1'b1, 8'h04);

    // Two bypass writes to one way, the later landing in the sample cycle.
    lkp_valid = 1'b1; lkp_index = 10'd11; lkp_tag = 20'h0000B;
    @(negedge clk);
    lkp_valid = 1'b0;
    upd_one(10'd11, 8'h04, mk_cl(1'b1, 4'b0001, 20'h0000A));
    upd_one(10'd11, 8'h04, mk_cl(1'b1, 4'b1000, 20'h0000B));
    wait_rsp(3, lat);
    check_val("byp2_latency", lat, 4);
    check_rsp("byp11", 1'b1, 8'h04, 4'b1000, 1'b0, 8'h01);
    lkp_rsp(10'd11, 20'h0000A, lat);
    check_rsp("stale11", 1'b0, 8'h00, 4'b0000, 1'b0, 8'h01);

    // Lookup and update requested together: update first.
    lkp_valid = 1'b1; lkp_index = 10'd13; lkp_tag = 20'h13;
    upd_valid = 1'b1; upd_index = 10'd20; upd_ways = 8'h01; upd_cline = mk_cl(1'b1, 4'b0011, 20'h20);
    #1;
    check_val("arb_lkp_ready", lkp_ready, 1'b0);
    @(negedge clk);
    upd_valid = 1'b0;
    check_val("arb_wr_first", sf_wr_ways_q, 8'h01);
    check_val("arb_wr_index", sf_index_q, 10'd20);
    check_val("arb_wr_rd_en", sf_rd_en_q, 1'b0);
    @(negedge clk);
    lkp_valid = 1'b0;
    check_val("arb_rd_second", sf_rd_en_q, 1'b1);
    check_val("arb_rd_index", sf_index_q, 10'd13);
    wait_rsp(1, lat);
    check_val("arb_latency", lat, 4);
    check_rsp("arb13", 1'b0, 8'h00, 4'b0000, 1'b0, 8'h01);

    // Reset with two lookups in flight.
    lkp_valid = 1'b1; lkp_index = 10'd5; lkp_tag = 20'h12345;
    @(negedge clk);
    lkp_index = 10'd7;
    @(negedge clk);
    lkp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst2_rsp_valid", rsp_valid, 1'b0);
    check_val("rst2_init_done", init_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (k == 0) begin
        check_val("rst2_sweep_idx0", sf_index_q, 10'd0);
        check_val("rst2_sweep_ways", sf_wr_ways_q, 8'hFF);
      end
      if (k == 7) check_val("rst2_sweep_idx7", sf_index_q, 10'd7);
    end
    check_val("rst2_no_rsp", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
